// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision definitions for the FP add/sub datapaths.
// Field geometry, the canonical NaN output, flag bit positions and operand classes.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN_OUT = 32'hFFFF_FFFF;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Denormals land in ZERO because they are flushed on input.
    function automatic fp_class_e fp_classify(input logic [31:0] w);
        fp_class_e c;
        case (w[30:23])
            8'h00:   c = ZERO;
            8'hFF:   c = (w[22:0] == 23'd0) ? INF : NAN;
            default: c = NORM;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fp32_lzc.sv
// Combinational 28-bit leading-zero counter; returns 28 for an all-zero input.
module fp32_lzc (
    input  logic [27:0] value,
    output logic [4:0]  count
);

    // Scan from LSB upward so the highest set bit is the last one to write the count.
    always_comb begin
        count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            count = value[i] ? 5'(27 - i) : count;
        end
    end

endmodule

// File: rtl/single_precision_subtractor_pipe.sv
// Three-stage pipelined IEEE-754 single subtractor (operand1 - operand2) with
// valid/ready flow control; the whole pipe freezes while the output is stalled.
module single_precision_subtractor_pipe
    import fp32_pkg::*;
#(
    parameter int FLUSH_DENORM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Result,
    output logic [3:0]  flags
);

    logic        advance;
    logic        s1_valid, s2_valid;

    // Stage 1 combinational unpack/align
    logic [31:0] b_word;
    fp_class_e   cls1, cls2;
    logic [30:0] mag1, mag2, mag_a, mag_b;
    logic        swap, sign_a, sign_b, eff_sub, is_nan, is_inf;
    logic [23:0] sig_a, sig_b;
    logic [7:0]  exp_diff;
    logic [53:0] shift_ext;
    logic [26:0] sig_b_al;

    // Stage registers
    logic        s1_sign, s1_sub, s1_nan, s1_inf;
    logic [7:0]  s1_exp;
    logic [26:0] s1_sig_a, s1_sig_b;
    logic        s2_sign, s2_sub, s2_nan, s2_inf;
    logic [7:0]  s2_exp;
    logic [27:0] s2_sum;

    // Stage 3 combinational normalize/round/pack
    logic [4:0]  lz;
    logic [26:0] norm_m;
    logic [9:0]  norm_e, exp_r;
    logic        round_up, inexact;
    logic [23:0] rnd;
    logic [31:0] res_s;
    logic [3:0]  flg_s;

    assign in_ready = !(out_valid && !out_ready);
    assign advance  = in_ready;

    // Classify, order by magnitude and align the smaller significand.
    always_comb begin
        b_word   = {~operand2[31], operand2[30:0]};
        cls1     = fp_classify(operand1);
        cls2     = fp_classify(b_word);
        mag1     = (cls1 == ZERO && FLUSH_DENORM == 1) ? 31'd0 : operand1[30:0];
        mag2     = (cls2 == ZERO && FLUSH_DENORM == 1) ? 31'd0 : b_word[30:0];
        swap     = (mag2 > mag1);
        mag_a    = swap ? mag2 : mag1;
        mag_b    = swap ? mag1 : mag2;
        sign_a   = swap ? b_word[31] : operand1[31];
        sign_b   = swap ? operand1[31] : b_word[31];
        eff_sub  = (sign_a != sign_b);
        sig_a    = (mag_a[30:23] == 8'd0) ? 24'd0 : {1'b1, mag_a[22:0]};
        sig_b    = (mag_b[30:23] == 8'd0) ? 24'd0 : {1'b1, mag_b[22:0]};
        exp_diff = mag_a[30:23] - mag_b[30:23];
        is_nan   = (cls1 == NAN) || (cls2 == NAN) || (cls1 == INF && cls2 == INF && eff_sub);
        is_inf   = (cls1 == INF) || (cls2 == INF);
        shift_ext = {sig_b, 3'b000, 27'd0} >> exp_diff;
        if (exp_diff >= 8'd26) begin
            sig_b_al = {26'd0, |sig_b};
        end else begin
            sig_b_al = {shift_ext[53:28], shift_ext[27] | (|shift_ext[26:0])};
        end
    end

    // Pipeline valid bits and the output stage; all advance together or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_sign   <= 1'b0;
            s1_sub    <= 1'b0;
            s1_nan    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_exp    <= 8'd0;
            s1_sig_a  <= 27'd0;
            s1_sig_b  <= 27'd0;
            s2_sign   <= 1'b0;
            s2_sub    <= 1'b0;
            s2_nan    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_exp    <= 8'd0;
            s2_sum    <= 28'd0;
            Result    <= 32'd0;
            flags     <= 4'd0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            s1_sign   <= sign_a;
            s1_sub    <= eff_sub;
            s1_nan    <= is_nan;
            s1_inf    <= is_inf;
            s1_exp    <= mag_a[30:23];
            s1_sig_a  <= {sig_a, 3'b000};
            s1_sig_b  <= sig_b_al;
            s2_sign   <= s1_sign;
            s2_sub    <= s1_sub;
            s2_nan    <= s1_nan;
            s2_inf    <= s1_inf;
            s2_exp    <= s1_exp;
            s2_sum    <= s1_sub ? ({1'b0, s1_sig_a} - {1'b0, s1_sig_b})
                                : ({1'b0, s1_sig_a} + {1'b0, s1_sig_b});
            Result    <= res_s;
            flags     <= flg_s;
        end else begin
            s1_valid  <= s1_valid;
            s2_valid  <= s2_valid;
            out_valid <= out_valid;
        end
    end

    // Forcing bit 0 high caps the count at 27, which is the all-zero sum case.
    fp32_lzc u_lzc (
        .value ({s2_sum[26:0], 1'b1}),
        .count (lz)
    );

    // Normalize, round to nearest even and resolve specials into the packed result.
    always_comb begin
        if (s2_sum[27]) begin
            norm_m = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
            norm_e = {2'b00, s2_exp} + 10'd1;
        end else begin
            norm_m = s2_sum[26:0] << lz;
            norm_e = {2'b00, s2_exp} - {5'd0, lz};
        end
        inexact  = |norm_m[2:0];
        round_up = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
        rnd      = {1'b0, norm_m[25:3]} + {23'd0, round_up};
        exp_r    = norm_e + {9'd0, rnd[23]};
        flg_s    = 4'b0000;
        if (s2_nan) begin
            res_s = QNAN_OUT;
            flg_s[FLAG_INVALID] = 1'b1;
        end else if (s2_inf) begin
            res_s = {s2_sign, 8'hFF, 23'd0};
        end else if (!norm_m[26]) begin
            // Only an exact cancellation or two zeros reach here.
            res_s = {s2_sub ? 1'b0 : s2_sign, 31'd0};
        end else if (norm_e[9] || norm_e == 10'd0) begin
            res_s = {s2_sign, 31'd0};
            flg_s[FLAG_UNDERFLOW] = 1'b1;
            flg_s[FLAG_INEXACT]   = 1'b1;
        end else if (exp_r >= 10'd255) begin
            res_s = {s2_sign, 8'hFF, 23'd0};
            flg_s[FLAG_OVERFLOW] = 1'b1;
            flg_s[FLAG_INEXACT]  = 1'b1;
        end else begin
            res_s = {s2_sign, exp_r[7:0], rnd[22:0]};
            flg_s[FLAG_INEXACT] = inexact;
        end
    end

endmodule

// File: tb/tb_single_precision_subtractor_pipe.sv
// Directed self-checking bench for the pipelined FP32 subtractor: arithmetic
// corners, specials, latency, stall/backpressure ordering and mid-flight reset.
module tb_single_precision_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    logic [31:0] va [6] = '{32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000,
                            32'h4000_0000, 32'h3F80_0000, 32'h4080_0000};
    logic [31:0] vb [6] = '{32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000,
                            32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000};
    logic [31:0] vr [6] = '{32'h4000_0000, 32'h0000_0000, 32'h4000_0000,
                            32'h3F80_0000, 32'hBF80_0000, 32'h4040_0000};

    always #5 clk = ~clk;

    single_precision_subtractor_pipe #(.FLUSH_DENORM(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single operation with out_ready high; latency counted in edges from the accept edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic [3:0] f);
        int cyc;
        operand1  = a;
        operand2  = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, cyc, 32'd3);
        check({tag, "_res"}, Result, r);
        check({tag, "_flg"}, {28'd0, flags}, {28'd0, f});
        @(negedge clk);
    endtask

    initial begin
        int sent, got, cyc;
        bit acc, take, saw_block;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        operand1 = 32'd0;
        operand2 = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ovalid", {31'd0, out_valid}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_irdy", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_op("sub3m1",  32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000);
        run_op("x_m_x",   32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000);
        run_op("1_m_neg1",32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4'b0000);
        run_op("tie_even",32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 4'b0001);
        run_op("exact24", 32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF, 4'b0000);
        run_op("ovf",     32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4'b0101);
        run_op("nan_in",  32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 4'b1000);
        run_op("inf_inf", 32'h7F80_0000, 32'h7F80_0000, 32'hFFFF_FFFF, 4'b1000);
        run_op("inf_m_1", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'b0000);
        run_op("nzero",   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0000);
        run_op("unf",     32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 4'b0011);
        run_op("denorm",  32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 4'b0000);
        run_op("one_m_2", 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 4'b0000);

        // Back-to-back stream with the consumer stalled for 5 cycles once the pipe fills.
        sent = 0; got = 0; cyc = 0; saw_block = 1'b0;
        while (got < 6 && cyc < 60) begin
            in_valid  = (sent < 6);
            operand1  = va[(sent < 6) ? sent : 5];
            operand2  = vb[(sent < 6) ? sent : 5];
            out_ready = (cyc >= 8);
            #1;
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid) check($sformatf("stream_res%0d", got), Result, vr[got]);
            @(negedge clk);
            sent += int'(acc);
            got  += int'(take);
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_got", got, 32'd6);
        check("stream_sent", sent, 32'd6);
        check("stream_block", {31'd0, saw_block}, 32'd1);
        @(negedge clk);
        check("stream_drain", {31'd0, out_valid}, 32'd0);

        // Fill the pipe, then reset between edges and confirm recovery.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            operand1 = va[i];
            operand2 = vb[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("full_ovalid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_ovalid", {31'd0, out_valid}, 32'd0);
        check("arst_result", Result, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ovalid", {31'd0, out_valid}, 32'd0);
        run_op("post_rst", 32'h4080_0000, 32'h3F80_0000, 32'h4040_0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/single_precision_subtractor_pipe.md
Name: single_precision_subtractor_pipe

Overview:
- Pipelined IEEE-754 single-precision subtractor; computes Result = operand1 - operand2.
- Complements the existing combinational adder datapath.
- Three register stages with valid/ready handshakes on both sides, so it can sit between FPU issue logic and a result writeback queue.
- Flag encoding and NaN output pattern match the adder, so downstream logic treats both units identically.

Parameters:
- FLUSH_DENORM, 1, denormal inputs are treated as signed zero; denormal results flush to signed zero. Only value 1 is supported.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair is present.
- in_ready  output  1  block accepts the pair this cycle.
- operand1  input  32  minuend, IEEE-754 single.
- operand2  input  32  subtrahend, IEEE-754 single.
- out_valid  output  1  Result and flags are valid.
- out_ready  input  1  consumer takes the result this cycle.
- Result  output  32  difference, IEEE-754 single.
- flags  output  4  [3] invalid/NaN, [2] overflow, [1] underflow, [0] inexact.

Behaviour:
- Reset (async, rst=1): all stage valid bits = 0; out_valid=0, Result=0, flags=0. Asserting rst mid-operation discards in-flight operations; out_valid falls immediately, without waiting for a clock.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - in_ready = !(out_valid && !out_ready).
  - On a stall the whole pipe freezes and out_valid/Result/flags stay stable until accepted.
  - Latency is exactly 3 cycles from input accept to out_valid with no stall.
  - Throughput is 1 per cycle.
  - Ordering is preserved.
  - Accepting a new input while the output is being taken in the same cycle is legal.
- Stage 1 (unpack/align):
  - Invert operand2 sign.
  - Classify each operand as zero/denorm (flushed), normal, inf, or NaN.
  - Swap so that operand A has magnitude >= operand B (compare exponent then mantissa).
  - Effective operation is subtract when the signs (after inversion) differ, else add.
  - Right-shift B's 24-bit significand by the exponent difference into 27 bits (value + guard + round + sticky). Sticky is the OR of all bits shifted out; a difference >= 26 leaves B as sticky only.
- Stage 2 (add/sub): 28-bit add or subtract of the aligned significands; result sign = sign of A.
- Stage 3 (normalize/round/pack):
  - Carry out: right-shift 1 and exponent +1, keeping the sticky bit.
  - Otherwise left-shift by the leading-zero count and reduce the exponent by that count.
  - Round to nearest, ties to even, using G/R/S.
  - A mantissa carry from rounding increments the exponent.
- Specials and boundaries:
  - Any NaN input: Result=32'hFFFF_FFFF, flags=4'b1000.
  - +inf - +inf, or -inf - -inf: Result=32'hFFFF_FFFF, flags=4'b1000.
  - Otherwise an infinite input yields a correctly signed infinity with flags=0.
  - Exact zero difference (x - x) yields +0.
  - (-0) - (+0) yields -0.
  - Exponent >= 255 after rounding: Result = signed inf (exp 8'hFF, mant 0), flags=4'b0101.
  - Exponent <= 0 after normalization: Result = signed zero, flags=4'b0011.
  - flags[0]=1 whenever G|R|S was nonzero before rounding.

Decomposition:
- Shared package fp32_pkg:
  - Field widths and offsets (EXP_W=8, MAN_W=23, BIAS=127).
  - QNAN_OUT=32'hFFFF_FFFF.
  - Flag bit indices.
  - Class enum {ZERO, NORM, INF, NAN}.
- Sub-module fp32_lzc: combinational 28-bit leading-zero counter used by stage 3; verified stand-alone.

Test Plan:
- 0x40400000 - 0x3F800000 (3.0 - 1.0), out_ready=1 -> Result 0x40000000, flags 0, out_valid exactly 3 cycles after accept.
- 0x3F800000 - 0x3F800000 -> 0x00000000, flags 0. Also 0x3F800000 - 0xBF800000 -> 0x40000000, flags 0.
- 0x3F800000 - 0x33000000 (1 - 2^-25, tie) -> 0x3F800000, flags 4'b0001. Also 0x3F800000 - 0x33800000 -> 0x3F7FFFFF, flags 0.
- 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000, flags 4'b0101. Also 0x7FC00000 - 0x3F800000 -> 0xFFFFFFFF, flags 4'b1000. Also 0x7F800000 - 0x7F800000 -> 0xFFFFFFFF, flags 4'b1000.
- Back-to-back 6 inputs with out_ready held 0 for 5 cycles -> in_ready drops after the pipe fills, output stable during the stall, all 6 results delivered in order, none lost or duplicated.
- Pipe full, rst pulsed between edges -> out_valid 0 immediately; after release, a fresh input yields a correct result 3 cycles later.
